// File: rtl/sh4_bru_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sh4_bru_pkg                                                    |
// | Purpose : Shared types for the SH-4 sequential branch resolution unit:   |
// |           branch class enum, delay-slot FSM states, opcode match         |
// |           masks/patterns and small decode helpers.                       |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sh4_bru_pkg;

  typedef enum logic [3:0] {
    NONE, BF, BT, BFS, BTS, BRA, BSR, BRAF, BSRF, JMP, JSR, RTS, RTE
  } br_class_e;

  typedef enum logic {
    S_NORM = 1'b0,
    S_SLOT = 1'b1
  } bru_state_e;

  // 8-bit displacement conditional forms: 1000 1xx1 dddd dddd
  localparam logic [15:0] M_BCC   = 16'hFF00;
  localparam logic [15:0] P_BT    = 16'h8900;
  localparam logic [15:0] P_BF    = 16'h8B00;
  localparam logic [15:0] P_BTS   = 16'h8D00;
  localparam logic [15:0] P_BFS   = 16'h8F00;
  // 12-bit displacement forms
  localparam logic [15:0] M_D12   = 16'hF000;
  localparam logic [15:0] P_BRA   = 16'hA000;
  localparam logic [15:0] P_BSR   = 16'hB000;
  // Register forms: Rn lives in bits [11:8]
  localparam logic [15:0] M_REG   = 16'hF0FF;
  localparam logic [15:0] P_BRAF  = 16'h0023;
  localparam logic [15:0] P_BSRF  = 16'h0003;
  localparam logic [15:0] P_JMP   = 16'h402B;
  localparam logic [15:0] P_JSR   = 16'h400B;
  // Fully specified opcodes
  localparam logic [15:0] P_RTS   = 16'h000B;
  localparam logic [15:0] P_RTE   = 16'h002B;

  function automatic br_class_e decode_class(input logic [15:0] raw);
    br_class_e c;
    c = NONE;
    if      ((raw & M_BCC) == P_BT)   c = BT;
    else if ((raw & M_BCC) == P_BF)   c = BF;
    else if ((raw & M_BCC) == P_BTS)  c = BTS;
    else if ((raw & M_BCC) == P_BFS)  c = BFS;
    else if ((raw & M_D12) == P_BRA)  c = BRA;
    else if ((raw & M_D12) == P_BSR)  c = BSR;
    else if (raw == P_RTS)            c = RTS;
    else if (raw == P_RTE)            c = RTE;
    else if ((raw & M_REG) == P_BRAF) c = BRAF;
    else if ((raw & M_REG) == P_BSRF) c = BSRF;
    else if ((raw & M_REG) == P_JMP)  c = JMP;
    else if ((raw & M_REG) == P_JSR)  c = JSR;
    return c;
  endfunction

  // Only plain BF/BT resolve without a delay slot.
  function automatic logic has_ds(input br_class_e c);
    return (c != NONE) && (c != BF) && (c != BT);
  endfunction

  function automatic logic writes_pr(input br_class_e c);
    return (c == BSR) || (c == BSRF) || (c == JSR);
  endfunction

endpackage : sh4_bru_pkg
`default_nettype wire

// File: rtl/sh4_bru_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sh4_bru_ras                                                    |
// | Purpose : Circular return-address stack. Push overwrites the oldest      |
// |           entry when full; pop of an empty stack is ignored. Only built  |
// |           when SH4_BRU_RAS_EN is defined.                                |
// | Ports   : clk, rst_n        clock, async active-low reset                |
// |           push_i, data_i    push data_i on top                           |
// |           pop_i             discard top entry                            |
// |           top_o, empty_o    current top entry and empty flag             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sh4_bru_ras
  import sh4_bru_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;     // next free slot
  logic [PTR_W:0]    cnt_q;     // live entries, saturates at DEPTH
  logic [PTR_W-1:0]  ptr_m1_w;

  assign ptr_m1_w = ptr_q - PTR_W'(1);
  assign top_o    = mem_q[ptr_m1_w];
  assign empty_o  = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (cnt_q != (PTR_W+1)'(DEPTH)) cnt_q <= cnt_q + (PTR_W+1)'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_m1_w;
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

endmodule : sh4_bru_ras
`default_nettype wire

// File: rtl/sh4_bru_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sh4_bru_seq                                                    |
// | Purpose : Registered, valid/ready branch resolution unit for the SH-4    |
// |           integer pipeline. Decodes branches, computes target and PR     |
// |           writeback, tracks the delay slot and issues the redirect once  |
// |           the slot instruction retires. Optional return-address stack    |
// |           prediction check enabled by macro SH4_BRU_RAS_EN.              |
// | Ports   : clk, rst_n, flush                 clock/reset/pipeline flush   |
// |           in_valid/in_ready + in_* operands instruction input            |
// |           out_valid/out_ready + out_* flags registered result            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sh4_bru_seq
  import sh4_bru_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_pr,
  input  logic [ADDR_W-1:0] in_spc,
  input  logic              in_t,
  input  logic [15:0]       in_raw,
  input  logic [ADDR_W-1:0] in_opl,
  input  logic [ADDR_W-1:0] in_oph,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_redirect,
  output logic [ADDR_W-1:0] out_target,
  output logic              out_write_pr,
  output logic [ADDR_W-1:0] out_pr_value,
  output logic              out_slot_illegal,
  output logic              out_ras_hit
);

  bru_state_e        state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic              valid_q, taken_q, redirect_q, wpr_q, illegal_q, hit_q;
  logic [ADDR_W-1:0] target_q, prv_q;
  logic              taken_d, redirect_d, wpr_d, illegal_d, hit_d;
  logic [ADDR_W-1:0] target_d;

  br_class_e         cls_w;
  logic              is_br_w, cond_ok_w, taken_w, ds_w, accept_w;
  logic [ADDR_W-1:0] target_w, prv_w;
  logic              push_w, pop_w;

  // ---------------- decode / target ----------------
  assign cls_w   = decode_class(in_raw);
  assign is_br_w = (cls_w != NONE);
  assign ds_w    = has_ds(cls_w);
  assign prv_w   = in_pc + ADDR_W'(4);

  always_comb begin
    cond_ok_w = 1'b1;
    case (cls_w)
      BF, BFS: cond_ok_w = !in_t;
      BT, BTS: cond_ok_w = in_t;
      default: cond_ok_w = 1'b1;
    endcase
  end
  assign taken_w = is_br_w && cond_ok_w;

  always_comb begin
    target_w = in_opl + in_oph;
    case (cls_w)
      JMP, JSR: target_w = in_oph;
      RTS:      target_w = in_pr;
      RTE:      target_w = in_spc;
      default:  target_w = in_opl + in_oph;
    endcase
  end

  // ---------------- handshake ----------------
  assign in_ready = !valid_q || out_ready;
  // A flush in the same cycle drops the incoming instruction.
  assign accept_w = in_valid && in_ready && !flush;

  // ---------------- delay-slot FSM ----------------
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    taken_d    = 1'b0;
    redirect_d = 1'b0;
    target_d   = target_w;
    wpr_d      = 1'b0;
    illegal_d  = 1'b0;
    push_w     = 1'b0;
    pop_w      = 1'b0;
    case (state_q)
      S_NORM: begin
        if (accept_w) begin
          taken_d    = taken_w;
          redirect_d = taken_w && !ds_w;
          wpr_d      = taken_w && writes_pr(cls_w);
          push_w     = taken_w && writes_pr(cls_w);
          pop_w      = (cls_w == RTS);
          if (taken_w && ds_w) begin
            tgt_d   = target_w;
            state_d = S_SLOT;
          end
        end
      end
      S_SLOT: begin
        // The slot retires the pending branch; its own branch effects are
        // suppressed and a branch here is reported as slot-illegal.
        if (accept_w) begin
          redirect_d = 1'b1;
          target_d   = tgt_q;
          illegal_d  = is_br_w;
          state_d    = S_NORM;
        end
      end
      default: state_d = S_NORM;
    endcase
    if (flush) state_d = S_NORM;
  end

  // ---------------- optional return-address stack ----------------
`ifdef SH4_BRU_RAS_EN
  logic [ADDR_W-1:0] ras_top_w;
  logic              ras_empty_w;

  sh4_bru_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .data_i  (prv_w),
    .top_o   (ras_top_w),
    .empty_o (ras_empty_w)
  );

  assign hit_d = pop_w && !ras_empty_w && (ras_top_w == in_pr);
`else
  logic unused_ras_w;
  assign unused_ras_w = push_w ^ pop_w ^ (RAS_DEPTH != 0);
  assign hit_d        = 1'b0;
`endif

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NORM;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      wpr_q      <= 1'b0;
      prv_q      <= '0;
      illegal_q  <= 1'b0;
      hit_q      <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_w) begin
      valid_q    <= 1'b1;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      wpr_q      <= wpr_d;
      prv_q      <= prv_w;
      illegal_q  <= illegal_d;
      hit_q      <= hit_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid        = valid_q;
  assign out_taken        = taken_q;
  assign out_redirect     = redirect_q;
  assign out_target       = target_q;
  assign out_write_pr     = wpr_q;
  assign out_pr_value     = prv_q;
  assign out_slot_illegal = illegal_q;
  assign out_ras_hit      = hit_q;

endmodule : sh4_bru_seq
`default_nettype wire

// File: tb/tb_sh4_bru_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sh4_bru_seq                                                 |
// | Purpose : Scoreboard bench for sh4_bru_seq: directed scenarios followed  |
// |           by random traffic, checked against a behavioural model.        |
// |           Honours SH4_BRU_RAS_EN for the return-stack expectation.       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sh4_bru_seq;

  localparam int AW = 32;
  localparam int RD = 4;

  // branch class codes used by the model
  localparam int K_NONE = 0, K_BF = 1, K_BT = 2, K_BFS = 3, K_BTS = 4, K_BRA = 5,
                 K_BSR = 6, K_BRAF = 7, K_BSRF = 8, K_JMP = 9, K_JSR = 10,
                 K_RTS = 11, K_RTE = 12;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic          in_t = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] in_pc = '0, in_pr = '0, in_spc = '0, in_opl = '0, in_oph = '0;
  logic [15:0]   in_raw = 16'h0009;
  logic          in_ready, out_valid, out_taken, out_redirect, out_write_pr;
  logic          out_slot_illegal, out_ras_hit;
  logic [AW-1:0] out_target, out_pr_value;

  sh4_bru_seq #(.ADDR_W(AW), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pr(in_pr), .in_spc(in_spc), .in_t(in_t),
    .in_raw(in_raw), .in_opl(in_opl), .in_oph(in_oph),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_redirect(out_redirect), .out_target(out_target),
    .out_write_pr(out_write_pr), .out_pr_value(out_pr_value),
    .out_slot_illegal(out_slot_illegal), .out_ras_hit(out_ras_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          taken;
    logic          redirect;
    logic [AW-1:0] target;
    logic          wpr;
    logic [AW-1:0] prv;
    logic          illegal;
    logic          hit;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] ras_m[$];
  int            total = 0;
  int            bad   = 0;
  bit            m_valid = 1'b0;
  bit            m_slot  = 1'b0;
  logic [AW-1:0] m_pend  = '0;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
    end
  endtask

  // Opcode classification straight from the SH-4 encoding tables.
  function automatic int bclass(input logic [15:0] r);
    logic [3:0] n3, n0;
    logic [7:0] lo;
    n3 = r[15:12];
    n0 = r[3:0];
    lo = r[7:0];
    if (n3 == 4'h8) begin
      case (r[11:8])
        4'h9: return K_BT;
        4'hB: return K_BF;
        4'hD: return K_BTS;
        4'hF: return K_BFS;
        default: return K_NONE;
      endcase
    end
    if (n3 == 4'hA) return K_BRA;
    if (n3 == 4'hB) return K_BSR;
    if (r == 16'h000B) return K_RTS;
    if (r == 16'h002B) return K_RTE;
    if (n3 == 4'h0 && lo == 8'h23) return K_BRAF;
    if (n3 == 4'h0 && lo == 8'h03) return K_BSRF;
    if (n3 == 4'h4 && lo == 8'h2B) return K_JMP;
    if (n3 == 4'h4 && lo == 8'h0B && n0 == 4'hB) return K_JSR;
    return K_NONE;
  endfunction

  // Model update for one rising edge, using the inputs the bench drove.
  task automatic model_edge();
    bit   acc;
    int   k;
    bit   tk, ds, link;
    exp_t e;
    logic [AW-1:0] tgt;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    if (flush) begin
      exp_q.delete();      // a stalled beat is dropped, a consumed one is gone
      m_valid = 1'b0;
      m_slot  = 1'b0;
    end else if (acc) begin
      k = bclass(in_raw);
      case (k)
        K_JMP, K_JSR: tgt = in_oph;
        K_RTS:        tgt = in_pr;
        K_RTE:        tgt = in_spc;
        default:      tgt = in_opl + in_oph;
      endcase
      if (k == K_BF || k == K_BFS)      tk = !in_t;
      else if (k == K_BT || k == K_BTS) tk = in_t;
      else                              tk = (k != K_NONE);
      ds   = (k != K_NONE) && (k != K_BF) && (k != K_BT);
      link = (k == K_BSR) || (k == K_BSRF) || (k == K_JSR);
      e = '0;
      e.prv = in_pc + 32'd4;
      if (m_slot) begin
        e.redirect = 1'b1;
        e.target   = m_pend;
        e.illegal  = (k != K_NONE);
        m_slot     = 1'b0;
      end else begin
        e.taken    = tk;
        e.redirect = tk && !ds;
        e.target   = tgt;
        e.wpr      = tk && link;
`ifdef SH4_BRU_RAS_EN
        if (k == K_RTS && ras_m.size() > 0) begin
          e.hit = (ras_m[$] == in_pr);
          void'(ras_m.pop_back());
        end
        if (tk && link) begin
          ras_m.push_back(in_pc + 32'd4);
          if (ras_m.size() > RD) void'(ras_m.pop_front());
        end
`endif
        if (tk && ds) begin
          m_slot = 1'b1;
          m_pend = tgt;
        end
      end
      exp_q.push_back(e);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] pc, input logic [AW-1:0] pr,
                       input logic t, input logic [15:0] raw, input logic [AW-1:0] opl,
                       input logic [AW-1:0] oph, input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_pr = pr; in_spc = pr ^ 32'h5A5A_0000; in_t = t;
    in_raw = raw; in_opl = opl; in_oph = oph; out_ready = rdy; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 16'h0009, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: compares every beat the DUT hands downstream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected got=valid want=none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("taken",    {31'd0, out_taken},        {31'd0, e.taken});
          chk("redirect", {31'd0, out_redirect},     {31'd0, e.redirect});
          if (e.redirect || e.taken) chk("target", out_target, e.target);
          chk("write_pr", {31'd0, out_write_pr},     {31'd0, e.wpr});
          chk("pr_value", out_pr_value,              e.prv);
          chk("slot_ill", {31'd0, out_slot_illegal}, {31'd0, e.illegal});
          chk("ras_hit",  {31'd0, out_ras_hit},      {31'd0, e.hit});
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_valid",    {31'd0, out_valid},        32'd0);
    chk("rst_taken",    {31'd0, out_taken},        32'd0);
    chk("rst_redirect", {31'd0, out_redirect},     32'd0);
    chk("rst_target",   out_target,                32'd0);
    chk("rst_wpr",      {31'd0, out_write_pr},     32'd0);
    chk("rst_prv",      out_pr_value,              32'd0);
    chk("rst_illegal",  {31'd0, out_slot_illegal}, 32'd0);
    chk("rst_hit",      {31'd0, out_ras_hit},      32'd0);
  endtask

  task automatic rand_op(output logic [15:0] raw);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 14))
      0:  raw = {8'h89, r[7:0]};
      1:  raw = {8'h8B, r[7:0]};
      2:  raw = {8'h8D, r[7:0]};
      3:  raw = {8'h8F, r[7:0]};
      4:  raw = {4'hA, r[11:0]};
      5:  raw = {4'hB, r[11:0]};
      6:  raw = {4'h0, r[11:8], 8'h23};
      7:  raw = {4'h0, r[11:8], 8'h03};
      8:  raw = {4'h4, r[11:8], 8'h2B};
      9:  raw = {4'h4, r[11:8], 8'h0B};
      10: raw = 16'h000B;
      11: raw = 16'h002B;
      12: raw = 16'h0009;
      13: raw = {4'h3, r[11:4], 4'hC};
      default: raw = {4'h6, r[11:4], 4'h3};
    endcase
  endtask

  initial begin
    logic [15:0]   raw;
    logic [AW-1:0] pc, pr;
    rst_n = 1'b0;
    #12;
    check_reset_outputs();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BT taken, no delay slot
    cycle(1, 32'h8C001000, 0, 1, 16'h8904, 32'h8C001004, 32'h10, 1, 0);
    // BSR then NOP slot
    cycle(1, 32'h8C000100, 0, 0, 16'hBFF8, 32'h8C000104, 32'hFFFFFFF0, 1, 0);
    cycle(1, 32'h8C000104, 0, 0, 16'h0009, 32'h8C000108, 0, 1, 0);
    // JMP with BRA in slot
    cycle(1, 32'h8C000200, 0, 0, 16'h432B, 32'h8C000204, 32'hA0000000, 1, 0);
    cycle(1, 32'h8C000202, 0, 0, 16'hA010, 32'h8C000206, 32'h20, 1, 0);
    // BF/S not taken, then ADD
    cycle(1, 32'h8C000300, 0, 1, 16'h8F05, 32'h8C000304, 32'h0A, 1, 0);
    cycle(1, 32'h8C000302, 0, 1, 16'h312C, 32'h8C000306, 0, 1, 0);
    // Backpressure after JSR
    cycle(1, 32'h00000100, 0, 0, 16'h410B, 32'h104, 32'h2000, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h102, 0, 0, 16'h0009, 32'h106, 0, 0, 0);
    cycle(1, 32'h102, 0, 0, 16'h0009, 32'h106, 0, 1, 0);
    idle(2);
    // Flush during slot: following NOP must not redirect
    cycle(1, 32'h8C000400, 0, 0, 16'hA002, 32'h8C000404, 32'h4, 1, 0);
    cycle(1, 32'h8C000402, 0, 0, 16'h0009, 32'h8C000406, 0, 1, 1);
    cycle(1, 32'h8C000402, 0, 0, 16'h0009, 32'h8C000406, 0, 1, 0);
    // Return stack: JSR/RTS with matching, then mismatching PR
    cycle(1, 32'h100, 0, 0, 16'h420B, 32'h104, 32'h4000, 1, 0);
    cycle(1, 32'h102, 0, 0, 16'h0009, 32'h106, 0, 1, 0);
    cycle(1, 32'h4000, 32'h104, 0, 16'h000B, 32'h4004, 0, 1, 0);
    cycle(1, 32'h4002, 0, 0, 16'h0009, 32'h4006, 0, 1, 0);
    cycle(1, 32'h100, 0, 0, 16'h420B, 32'h104, 32'h4000, 1, 0);
    cycle(1, 32'h102, 0, 0, 16'h0009, 32'h106, 0, 1, 0);
    cycle(1, 32'h4000, 32'h999, 0, 16'h000B, 32'h4004, 0, 1, 0);
    cycle(1, 32'h4002, 0, 0, 16'h0009, 32'h4006, 0, 1, 0);
    // Reset in the middle of a slot loses the pending redirect
    cycle(1, 32'h8C000500, 0, 0, 16'hA00A, 32'h8C000504, 32'h14, 1, 0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    exp_q.delete(); ras_m.delete(); m_valid = 1'b0; m_slot = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 32'h8C000502, 0, 0, 16'h0009, 32'h8C000506, 0, 1, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_op(raw);
      pc = $urandom & 32'hFFFF_FFFE;
      pr = $urandom;
      if (ras_m.size() > 0 && $urandom_range(0, 1) == 1) pr = ras_m[$];
      cycle($urandom_range(0, 3) != 0, pc, pr, 1'($urandom), raw, pc + 32'd4,
            $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    idle(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sh4_bru_seq
`default_nettype wire

// File: doc/sh4_bru_seq.md
Name: sh4_bru_seq

Overview:
- Registered, handshaked branch resolution unit for the SH-4 integer pipeline; next generation of the combinational branch decoder.
- Decodes all SH-4 branch opcodes, computes target and PR writeback value, and tracks the delay slot with a small FSM.
- Issues one redirect after the slot instruction retires, and flags illegal slot instructions.
- Sits between the operand-read stage and writeback/fetch-redirect logic.

Parameters:
- ADDR_W, 32, width of PC, PR, SPC and target.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2; used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (exception/interrupt)
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept (= !out_valid || out_ready)
- in_pc  in  ADDR_W  PC of instruction
- in_pr  in  ADDR_W  current PR
- in_spc  in  ADDR_W  current SPC
- in_t  in  1  T bit
- in_raw  in  16  opcode
- in_opl  in  ADDR_W  operand low (PC+4 for relative forms)
- in_oph  in  ADDR_W  operand high (scaled sign-extended disp, or Rn)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_taken  out  1  this instruction is a taken branch
- out_redirect  out  1  fetch must redirect to out_target now
- out_target  out  ADDR_W  redirect/branch target
- out_write_pr  out  1  write out_pr_value to PR
- out_pr_value  out  ADDR_W  in_pc+4
- out_slot_illegal  out  1  branch found in delay slot (slot-illegal exception)
- out_ras_hit  out  1  RTS target matched RAS prediction (optional feature)

Behaviour:
- Reset: all outputs 0, FSM=S_NORM, tgt_q=0, RAS pointer 0.
- Accept = in_valid && in_ready. Latency is 1 cycle: outputs register on accept and hold while out_valid && !out_ready.
- On out_ready with no new accept, out_valid clears.
- Decode and targets:
  - BF/BT: cond, no DS, target opl+oph.
  - BF/S, BT/S: cond, DS, target opl+oph.
  - BRA: DS, target opl+oph.
  - BSR: DS, PR write, target opl+oph.
  - BRAF: DS, target opl+oph.
  - BSRF: DS, PR write, target opl+oph.
  - JMP: DS, target oph.
  - JSR: DS, PR write, target oph.
  - RTS: DS, target in_pr.
  - RTE: DS, target in_spc.
  - BF taken when !T; BT taken when T.
- Adds wrap mod 2^ADDR_W. out_pr_value = in_pc+4 (also wraps).
- FSM S_NORM:
  - taken branch without DS: out_taken=1, out_redirect=1, out_target=target; stay.
  - taken branch with DS: out_taken=1, out_redirect=0, tgt_q<=target, go S_SLOT.
  - not-taken conditional or non-branch: all flags 0, out_target=target (don't care).
- FSM S_SLOT (next accepted instruction is the slot):
  - out_redirect=1, out_target=tgt_q.
  - slot's own branch effects suppressed: out_taken=0, out_write_pr=0.
  - out_slot_illegal=1 if slot opcode is any branch class (taken or not).
  - Return to S_NORM.
- out_write_pr only with out_taken in S_NORM.
- flush: out_valid<=0, FSM<=S_NORM, tgt_q kept; flush has priority over a same-cycle accept (input is dropped).
- Reset mid-slot returns to S_NORM immediately and loses the pending redirect.

Optional Feature:
- Macro: SH4_BRU_RAS_EN.
- Enabled:
  - RAS_DEPTH-entry circular return stack.
  - Push in_pc+4 on accepted taken BSR/BSRF/JSR in S_NORM; overflow overwrites the oldest entry.
  - Pop on accepted RTS in S_NORM; out_ras_hit = (top == in_pr) && stack non-empty.
  - Empty pop gives hit=0 and the pointer is unchanged.
  - Simultaneous push/pop cannot occur.
  - flush leaves the RAS unchanged.
- Disabled: no storage, out_ras_hit tied 0.

Decomposition:
- Shared package sh4_bru_pkg holds:
  - branch class enum: NONE, BF, BT, BFS, BTS, BRA, BSR, BRAF, BSRF, JMP, JSR, RTS, RTE
  - FSM state constants S_NORM and S_SLOT
  - opcode match masks
- Natural sub-module sh4_bru_ras: stack with push/pop/top/empty, instantiated only under the macro.

Test Plan:
- BT at pc=0x8C001000, T=1, opl=0x8C001004, oph=0x10 -> next cycle out_taken=1, out_redirect=1, out_target=0x8C001014.
- BSR pc=0x8C000100, opl=0x8C000104, oph=0xFFFFFFF0, then NOP:
  - BSR beat: taken=1, redirect=0, write_pr=1, pr_value=0x8C000104.
  - NOP beat: redirect=1, target=0x8C0000F4.
- JMP (oph=0xA0000000) followed by BRA in the slot -> slot beat: redirect=1, target=0xA0000000, slot_illegal=1, taken=0.
- BF/S with T=1 followed by ADD -> no redirect on either beat; FSM stays S_NORM.
- Backpressure: out_ready=0 for 3 cycles after a JSR -> in_ready=0 and outputs stable; the slot is accepted only after out_ready=1.
- flush during S_SLOT, then NOP -> NOP beat has redirect=0. With RAS enabled: JSR pc=0x100 then RTS with in_pr=0x104 gives ras_hit=1; with a mismatching PR it gives 0.
